ifft_core2_pipe: RTL and testbench

Pipelined radix-2 inverse butterfly with a valid/ready handshake. It is the inverse counterpart of the combinational forward butterfly core: it takes the pair (a, b) and twiddle W and produces X1 = (a + b) and X2 = (a − b)·conj(W), each optionally halved per stage, so cascaded stages undo the forward transform. It sits in the IFFT datapath between the stage-buffer read port and the stage-buffer write port.

---
 rtl/ifft_core2_pipe.sv | 142 ++++++++++++++
 tb/tb_ifft_core2_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_core2_pipe.sv
// ifft_core2_pipe
//   Three-stage pipelined radix-2 inverse butterfly with valid/ready flow
//   control. Produces X1 = (a + b) and X2 = (a - b) * conj(W), each optionally
//   halved (SCALE_EN), floor-truncated and saturated to DATA_WID bits.
//
// Ports
//   clk, rst                        clock, async active-high reset
//   fft_valid_i / fft_ready_o       input handshake (a, b, W)
//   fft_data_{re,im}1_i             operand a (signed)
//   fft_data_{re,im}2_i             operand b (signed)
//   fft_wn_{re,im}_i                twiddle W, not pre-conjugated (signed)
//   fft_valid_o / fft_ready_i       output handshake
//   fft_data_{re,im}1_o             X1
//   fft_data_{re,im}2_o             X2
module ifft_core2_pipe #(
  parameter int DATA_WID = 16,
  parameter int WN_WID   = 16,
  parameter int ACC_LEN  = 14,
  parameter int SCALE_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fft_valid_i,
  output logic                fft_ready_o,
  input  logic [DATA_WID-1:0] fft_data_re1_i,
  input  logic [DATA_WID-1:0] fft_data_im1_i,
  input  logic [DATA_WID-1:0] fft_data_re2_i,
  input  logic [DATA_WID-1:0] fft_data_im2_i,
  input  logic [WN_WID-1:0]   fft_wn_re_i,
  input  logic [WN_WID-1:0]   fft_wn_im_i,
  output logic                fft_valid_o,
  input  logic                fft_ready_i,
  output logic [DATA_WID-1:0] fft_data_re1_o,
  output logic [DATA_WID-1:0] fft_data_im1_o,
  output logic [DATA_WID-1:0] fft_data_re2_o,
  output logic [DATA_WID-1:0] fft_data_im2_o
);

  localparam int SW  = DATA_WID + 1;           // sum/difference width
  localparam int PW  = DATA_WID + WN_WID + 2;  // product-sum width
  localparam int SH2 = ACC_LEN + SCALE_EN;     // single combined shift for X2

  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic [DATA_WID-1:0] sat(input logic signed [PW-1:0] x);
    logic [DATA_WID-1:0] r;
    if (x > SAT_MAX)      r = SAT_MAX[DATA_WID-1:0];
    else if (x < SAT_MIN) r = SAT_MIN[DATA_WID-1:0];
    else                  r = x[DATA_WID-1:0];
    return r;
  endfunction

  function automatic logic signed [PW-1:0] sx(input logic signed [SW-1:0] v);
    return {{(PW-SW){v[SW-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] wx(input logic signed [WN_WID-1:0] v);
    return {{(PW-WN_WID){v[WN_WID-1]}}, v};
  endfunction

  // vld_pipe_q[0..2] = v1..v3
  logic [2:0] vld_pipe_q, vld_pipe_d;
  logic       en;

  logic signed [SW-1:0]     s_re_q, s_im_q, d_re_q, d_im_q;
  logic signed [SW-1:0]     s_re_d, s_im_d, d_re_d, d_im_d;
  logic signed [WN_WID-1:0] w_re_q, w_im_q, w_re_d, w_im_d;
  logic signed [SW-1:0]     s2_re_q, s2_im_q, s2_re_d, s2_im_d;
  logic signed [PW-1:0]     p_re_q, p_im_q, p_re_d, p_im_d;
  logic [DATA_WID-1:0]      x1_re_q, x1_im_q, x2_re_q, x2_im_q;
  logic [DATA_WID-1:0]      x1_re_d, x1_im_d, x2_re_d, x2_im_d;

  // Whole pipe advances together; only a held, unaccepted output stalls it.
  assign en          = !(vld_pipe_q[2] && !fft_ready_i);
  assign fft_ready_o = en;
  assign fft_valid_o = vld_pipe_q[2];

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s_re_d  = s_re_q;   s_im_d  = s_im_q;
    d_re_d  = d_re_q;   d_im_d  = d_im_q;
    w_re_d  = w_re_q;   w_im_d  = w_im_q;
    s2_re_d = s2_re_q;  s2_im_d = s2_im_q;
    p_re_d  = p_re_q;   p_im_d  = p_im_q;
    x1_re_d = x1_re_q;  x1_im_d = x1_im_q;
    x2_re_d = x2_re_q;  x2_im_d = x2_im_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[1:0], fft_valid_i};
      // S1: widen by one bit so a +/- b never overflows
      s_re_d = $signed({fft_data_re1_i[DATA_WID-1], fft_data_re1_i})
             + $signed({fft_data_re2_i[DATA_WID-1], fft_data_re2_i});
      s_im_d = $signed({fft_data_im1_i[DATA_WID-1], fft_data_im1_i})
             + $signed({fft_data_im2_i[DATA_WID-1], fft_data_im2_i});
      d_re_d = $signed({fft_data_re1_i[DATA_WID-1], fft_data_re1_i})
             - $signed({fft_data_re2_i[DATA_WID-1], fft_data_re2_i});
      d_im_d = $signed({fft_data_im1_i[DATA_WID-1], fft_data_im1_i})
             - $signed({fft_data_im2_i[DATA_WID-1], fft_data_im2_i});
      w_re_d = fft_wn_re_i;
      w_im_d = fft_wn_im_i;
      // S2: d * conj(W), full precision
      s2_re_d = s_re_q;
      s2_im_d = s_im_q;
      p_re_d  = sx(d_re_q) * wx(w_re_q) + sx(d_im_q) * wx(w_im_q);
      p_im_d  = sx(d_im_q) * wx(w_re_q) - sx(d_re_q) * wx(w_im_q);
      // S3: floor shift then clamp; X2 uses one combined shift to avoid
      // truncating twice
      x1_re_d = sat(sx(s2_re_q) >>> SCALE_EN);
      x1_im_d = sat(sx(s2_im_q) >>> SCALE_EN);
      x2_re_d = sat(p_re_q >>> SH2);
      x2_im_d = sat(p_im_q >>> SH2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s_re_q  <= '0;  s_im_q  <= '0;
      d_re_q  <= '0;  d_im_q  <= '0;
      w_re_q  <= '0;  w_im_q  <= '0;
      s2_re_q <= '0;  s2_im_q <= '0;
      p_re_q  <= '0;  p_im_q  <= '0;
      x1_re_q <= '0;  x1_im_q <= '0;
      x2_re_q <= '0;  x2_im_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s_re_q  <= s_re_d;   s_im_q  <= s_im_d;
      d_re_q  <= d_re_d;   d_im_q  <= d_im_d;
      w_re_q  <= w_re_d;   w_im_q  <= w_im_d;
      s2_re_q <= s2_re_d;  s2_im_q <= s2_im_d;
      p_re_q  <= p_re_d;   p_im_q  <= p_im_d;
      x1_re_q <= x1_re_d;  x1_im_q <= x1_im_d;
      x2_re_q <= x2_re_d;  x2_im_q <= x2_im_d;
    end
  end

  assign fft_data_re1_o = x1_re_q;
  assign fft_data_im1_o = x1_im_q;
  assign fft_data_re2_o = x2_re_q;
  assign fft_data_im2_o = x2_im_q;

endmodule

// File: tb/tb_ifft_core2_pipe.sv
// Bench for ifft_core2_pipe: two instances (SCALE_EN=1 and SCALE_EN=0) share
// one stimulus stream; outputs are scoreboarded against an arithmetic model.
module tb_ifft_core2_pipe;
  localparam int DW = 16;
  localparam int WW = 16;
  localparam int AL = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          valid_i, ready_i;
  logic [DW-1:0] are, aim, bre, bim;
  logic [WW-1:0] wre, wim;
  logic          rdy1, rdy0, vo1, vo0;
  logic [3:0][DW-1:0] o1, o0;   // {x2im, x2re, x1im, x1re}

  ifft_core2_pipe #(.DATA_WID(DW), .WN_WID(WW), .ACC_LEN(AL), .SCALE_EN(1)) dut1 (
    .clk(clk), .rst(rst), .fft_valid_i(valid_i), .fft_ready_o(rdy1),
    .fft_data_re1_i(are), .fft_data_im1_i(aim), .fft_data_re2_i(bre), .fft_data_im2_i(bim),
    .fft_wn_re_i(wre), .fft_wn_im_i(wim), .fft_valid_o(vo1), .fft_ready_i(ready_i),
    .fft_data_re1_o(o1[0]), .fft_data_im1_o(o1[1]), .fft_data_re2_o(o1[2]), .fft_data_im2_o(o1[3]));

  ifft_core2_pipe #(.DATA_WID(DW), .WN_WID(WW), .ACC_LEN(AL), .SCALE_EN(0)) dut0 (
    .clk(clk), .rst(rst), .fft_valid_i(valid_i), .fft_ready_o(rdy0),
    .fft_data_re1_i(are), .fft_data_im1_i(aim), .fft_data_re2_i(bre), .fft_data_im2_i(bim),
    .fft_wn_re_i(wre), .fft_wn_im_i(wim), .fft_valid_o(vo0), .fft_ready_i(ready_i),
    .fft_data_re1_o(o0[0]), .fft_data_im1_o(o0[1]), .fft_data_re2_o(o0[2]), .fft_data_im2_o(o0[3]));

  typedef struct packed { int x1re; int x1im; int x2re; int x2im; } res_t;
  typedef struct packed { res_t s1; res_t s0; } exp_t;

  exp_t q[$];
  int   ncmp = 0, nfail = 0, nout = 0;
  bit   held = 0, accepted = 0;
  logic [3:0][DW-1:0] snap1, snap0;

  // ---------------- reference model ----------------
  function automatic longint fdiv(longint n, longint d);
    longint r = n / d;
    if ((n % d) != 0 && n < 0) r = r - 1;
    return r;
  endfunction

  function automatic int sat(longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic res_t model(int ar, int ai, int br, int bi, int wr, int wi, int sc);
    res_t r;
    longint dr = ar - br, di = ai - bi;
    longint pr = dr * wr + di * wi;   // (a-b) * conj(W)
    longint pi = di * wr - dr * wi;
    r.x1re = sat(fdiv(ar + br, 1 << sc));
    r.x1im = sat(fdiv(ai + bi, 1 << sc));
    r.x2re = sat(fdiv(pr, longint'(1) << (AL + sc)));
    r.x2im = sat(fdiv(pi, longint'(1) << (AL + sc)));
    return r;
  endfunction

  function automatic res_t cur_exp(int sc);
    return model($signed(are), $signed(aim), $signed(bre), $signed(bim),
                 $signed(wre), $signed(wim), sc);
  endfunction

  function automatic res_t get(logic [3:0][DW-1:0] o);
    res_t r;
    r.x1re = $signed(o[0]); r.x1im = $signed(o[1]);
    r.x2re = $signed(o[2]); r.x2im = $signed(o[3]);
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string tag, longint obs, longint exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(string tag, res_t o, res_t e);
    chk({tag, ".x1re"}, o.x1re, e.x1re);
    chk({tag, ".x1im"}, o.x1im, e.x1im);
    chk({tag, ".x2re"}, o.x2re, e.x2re);
    chk({tag, ".x2im"}, o.x2im, e.x2im);
  endtask

  // One clock: scoreboard at the negedge, then step to just after posedge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    accepted = 0;
    if (rst) begin
      q.delete();
      held = 0;
    end else begin
      if (held) begin
        chk("hold.valid", vo1, 1);
        chk("hold.data1", o1, snap1);
        chk("hold.data0", o0, snap0);
      end
      if (vo1 && ready_i) begin
        nout++;
        chk("out.pending", q.size() > 0, 1);
        chk("out.valid0", vo0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk_res("out.s1", get(o1), e.s1);
          chk_res("out.s0", get(o0), e.s0);
        end
      end
      if (valid_i && rdy1) begin
        accepted = 1;
        e.s1 = cur_exp(1);
        e.s0 = cur_exp(0);
        q.push_back(e);
      end
      held  = vo1 && !ready_i;
      snap1 = o1;
      snap0 = o0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int ar, int ai, int br, int bi, int wr, int wi);
    are = DW'(ar); aim = DW'(ai); bre = DW'(br); bim = DW'(bi);
    wre = WW'(wr); wim = WW'(wi);
  endtask

  // Hold the current pair valid until accepted (bounded).
  task automatic send(bit rnd_ready);
    int n = 0;
    valid_i = 1;
    do begin
      if (rnd_ready) ready_i = ($urandom_range(0, 3) != 0);
      cyc();
      n++;
    end while (!accepted && n < 64);
    if (!accepted) chk("send.timeout", accepted, 1);
  endtask

  // Single pair into an empty pipe: valid appears after the third edge.
  task automatic spec_vec(string tag, int ar, int ai, int br, int bi, int wr, int wi,
                          bit use0, res_t e);
    ready_i = 1;
    drive(ar, ai, br, bi, wr, wi);
    valid_i = 1;
    cyc();
    valid_i = 0;
    chk({tag, ".lat1"}, vo1, 0);
    cyc();
    chk({tag, ".lat2"}, vo1, 0);
    cyc();
    chk({tag, ".lat3"}, use0 ? vo0 : vo1, 1);
    chk_res(tag, use0 ? get(o0) : get(o1), e);
    cyc();
    chk({tag, ".after"}, vo1, 0);
  endtask

  function automatic int r16();
    case ($urandom_range(0, 7))
      0: return 32767;
      1: return -32768;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  function automatic res_t mk(int a, int b, int c, int d);
    res_t r;
    r.x1re = a; r.x1im = b; r.x2re = c; r.x2im = d;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    res_t head;
    rst = 1; valid_i = 0; ready_i = 1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst.valid_o", vo1, 0);
    chk("rst.data1", o1, 0);
    chk("rst.data0", o0, 0);
    chk("rst.ready_o", rdy1, 1);
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("post_rst.ready_o", rdy1, 1);

    // directed vectors (1.0 = 16384)
    spec_vec("w1",   100, -50, 20, 30, 16384, 0, 0, mk(60, -10, 40, -40));
    spec_vec("wj",   100, -50, 20, 30, 0, 16384, 0, mk(60, -10, -40, -40));
    spec_vec("floor", -3, 0, 0, 0, 16384, 0, 0, mk(-2, 0, -2, 0));
    spec_vec("sat",  32767, 0, -32768, 0, 16384, 0, 1, mk(-1, 0, 32767, 0));

    // backpressure: downstream stalled after first input
    ready_i = 0;
    drive(1000, 2000, 300, -400, 11585, -11585); send(0);
    head = model(1000, 2000, 300, -400, 11585, -11585, 1);
    drive(-500, 700, 250, 125, 16384, 0);        send(0);
    drive(32000, -32000, -32000, 32000, 0, -16384); send(0);
    chk("bp.ready_low", rdy1, 0);
    chk("bp.valid", vo1, 1);
    chk_res("bp.head", get(o1), head);
    drive(7, -9, 11, 13, -16384, 0);
    valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp.no_accept", accepted, 0);
      chk("bp.ready_held_low", rdy1, 0);
    end
    ready_i = 1;
    cyc();
    chk("bp.accept_on_release", accepted, 1);
    drive(-1234, 4321, 999, -999, 5000, 6000); send(0);
    valid_i = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("bp.drained", q.size(), 0);
    chk("bp.count", nout, 9);

    // reset with three entries in flight
    ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      drive(r16(), r16(), r16(), r16(), r16(), r16());
      send(0);
    end
    valid_i = 0;
    #2 rst = 1;
    #1;
    chk("mrst.valid_o", vo1, 0);
    chk("mrst.data1", o1, 0);
    chk("mrst.data0", o0, 0);
    chk("mrst.ready_o", rdy1, 1);
    cyc();
    rst = 0;
    cyc();
    chk("mrst.no_stale", vo1, 0);
    spec_vec("mrst.first", 555, -666, 111, 222, 8000, -3000, 0,
             model(555, -666, 111, 222, 8000, -3000, 1));

    // randomized stream with random valid gaps and backpressure
    for (int i = 0; i < 80; i++) begin
      drive(r16(), r16(), r16(), r16(), r16(), r16());
      send(1);
      if ($urandom_range(0, 3) == 0) begin
        valid_i = 0;
        ready_i = ($urandom_range(0, 1) != 0);
        cyc();
      end
    end
    valid_i = 0;
    ready_i = 1;
    for (int i = 0; i < 6; i++) cyc();
    chk("rnd.drained", q.size(), 0);
    chk("rnd.valid_idle", vo1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
